// File: rtl/psum_ofifo_pkg.sv
// Shared sizing for the systolic output collector. These defaults match
// mac_row, so the column packing of its psum bus lines up with this block.
//   PSUM_BW : width of one psum word
//   COL     : columns per row (one FIFO each)
//   DEPTH   : entries per column FIFO (power of 2, >= 2)
//   PTR_BW  : log2(DEPTH)
//   col_lsb : LSB of column i inside a packed row, i.e. the slice
//             [bw*(i+1)-1 : bw*i] is written as [col_lsb(bw,i) +: bw]
package psum_ofifo_pkg;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 64;
    localparam int PTR_BW  = $clog2(DEPTH);

    function automatic int col_lsb(input int bw, input int i);
        return bw * i;
    endfunction
endpackage

// File: rtl/psum_ofifo_col.sv
// ofifo_col: single-column first-word-fall-through FIFO.
//   clk, reset : clock, async active-high reset (pointers/count/ovf only)
//   wr         : write strobe for din
//   pop        : pop head (caller guarantees the FIFO is non-empty)
//   dout       : current head entry, mem[rptr]
//   count      : occupancy, 0..depth
//   full/empty : count==depth / count==0
//   ovf        : sticky, set when a write is dropped
module ofifo_col #(
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int ptr_bw  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic [ptr_bw:0]    count,
    output logic               full,
    output logic               empty,
    output logic               ovf
);
    logic [psum_bw-1:0] mem [depth];
    logic [ptr_bw-1:0]  wptr, rptr;
    logic               accept;

    assign full   = (count == (ptr_bw+1)'(depth));
    assign empty  = (count == '0);
    // A pop on the same edge frees a slot, so a full FIFO still takes the write.
    assign accept = wr && (!full || pop);
    assign dout   = mem[rptr];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;   // wraps at depth-1
            if (pop)    rptr <= rptr + 1'b1;
            count <= count + (ptr_bw+1)'(accept) - (ptr_bw+1)'(pop);
            if (wr && !accept) ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: output collector for one mac_row. Each column buffers its
// psums independently (columns fire skewed in time); a whole row is
// released only once every column holds data, and is popped in one go.
//   clk, reset : clock, async active-high reset
//   in         : packed psum row, column i at [psum_bw*(i+1)-1 : psum_bw*i]
//   wr         : per-column write strobes (row valid bits)
//   rd         : pop one row (ignored while o_valid=0)
//   out        : head row (FWFT), zero while o_valid=0
//   o_valid    : every column non-empty
//   o_full     : some column full;  o_ready = !o_full
//   o_ovf      : sticky per-column overflow
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH,
    parameter int ptr_bw  = PTR_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [col-1:0]         o_ovf
);
    logic [col-1:0]              col_full, col_empty;
    logic [col-1:0][ptr_bw:0]    col_count;
    logic [col-1:0][psum_bw-1:0] col_dout;
    logic                        pop;

    assign o_valid = ~|col_empty;
    assign o_full  = |col_full;
    assign o_ready = ~o_full;
    // All columns advance together; a pop only happens on a complete row.
    assign pop     = rd & o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth),
            .ptr_bw  (ptr_bw)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .pop   (pop),
            .din   (in[col_lsb(psum_bw, i) +: psum_bw]),
            .dout  (col_dout[i]),
            .count (col_count[i]),
            .full  (col_full[i]),
            .empty (col_empty[i]),
            .ovf   (o_ovf[i])
        );

        assign out[col_lsb(psum_bw, i) +: psum_bw] = o_valid ? col_dout[i] : '0;

        count_in_range: assert property (@(posedge clk) disable iff (reset)
            col_count[i] <= (ptr_bw+1)'(depth));
    end
endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;
    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [BW*COL-1:0]   in, out;
    logic [COL-1:0]      wr, o_ovf;
    logic                rd, o_valid, o_full, o_ready;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of words per column plus sticky overflow bits.
    logic [BW-1:0]  mq [COL][$];
    logic [COL-1:0] m_ovf;

    psum_ofifo dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [BW*COL-1:0] m_out();
        logic [BW*COL-1:0] r = '0;
        if (m_valid()) for (int c = 0; c < COL; c++) r[c*BW +: BW] = mq[c][0];
        return r;
    endfunction

    function automatic logic [BW*COL-1:0] rand_row();
        logic [BW*COL-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    function automatic void m_clear();
        for (int c = 0; c < COL; c++) mq[c].delete();
        m_ovf = '0;
    endfunction

    // One clock: drive, advance model on the edge, return 1 time unit later.
    task automatic cycle(input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
        logic pop, was_full;
        wr = w; in = d; rd = r;
        @(posedge clk);
        pop = r && m_valid();
        for (int c = 0; c < COL; c++) begin
            was_full = (mq[c].size() == DEPTH);
            if (pop) void'(mq[c].pop_front());
            if (w[c]) begin
                if (!was_full || pop) mq[c].push_back(d[c*BW +: BW]);
                else                  m_ovf[c] = 1'b1;
            end
        end
        #1;
        wr = '0; rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
        m_clear();
        #12;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", out); end
        checks++; if (o_full !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL reset_full_ready got=%b%b exp=01", o_full, o_ready); end
        checks++; if (o_ovf !== '0) begin errors++; $display("FAIL reset_ovf got=%h exp=0", o_ovf); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_stagger();
        logic [BW*COL-1:0] d;
        logic [BW*COL-1:0] exp_row = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
        for (int c = 0; c < COL; c++) begin
            d = '0;
            d[c*BW +: BW] = 16'h1000 + 16'(c);
            cycle(COL'(1) << c, d, 1'b0);
            checks++; if (o_valid !== (c == COL-1)) begin errors++; $display("FAIL stagger_valid c=%0d got=%b exp=%b", c, o_valid, (c == COL-1)); end
            checks++; if (out !== m_out()) begin errors++; $display("FAIL stagger_out c=%0d got=%h exp=%h", c, out, m_out()); end
        end
        checks++; if (out !== exp_row) begin errors++; $display("FAIL stagger_row got=%h exp=%h", out, exp_row); end
        cycle('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stagger_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_back_to_back();
        logic [BW*COL-1:0] d;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'(16*k + c);
            cycle('1, d, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'(16*k + c);
            checks++; if (out !== d || o_valid !== 1'b1) begin errors++; $display("FAIL b2b_row k=%0d got=%h exp=%h", k, out, d); end
            cycle('0, '0, 1'b1);
        end
        checks++; if (o_valid !== 1'b0 || out !== '0) begin errors++; $display("FAIL b2b_empty got=%b/%h exp=0/0", o_valid, out); end
    endtask

    task automatic test_full_ovf();
        repeat (DEPTH) cycle('1, rand_row(), 1'b0);
        checks++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL full_flags got=%b%b exp=10", o_full, o_ready); end
        cycle(8'h08, rand_row(), 1'b0);
        checks++; if (o_ovf !== 8'h08) begin errors++; $display("FAIL ovf_set got=%h exp=08", o_ovf); end
        checks++; if (o_full !== 1'b1 || out !== m_out()) begin errors++; $display("FAIL ovf_hold got=%b/%h exp=1/%h", o_full, out, m_out()); end
        cycle('1, rand_row(), 1'b1);
        checks++; if (o_full !== 1'b1 || o_ovf !== 8'h08) begin errors++; $display("FAIL full_popwr got=%b/%h exp=1/08", o_full, o_ovf); end
        checks++; if (out !== m_out()) begin errors++; $display("FAIL full_popwr_out got=%h exp=%h", out, m_out()); end
        for (int n = 0; n < DEPTH; n++) begin
            checks++; if (out !== m_out()) begin errors++; $display("FAIL full_drain n=%0d got=%h exp=%h", n, out, m_out()); end
            cycle('0, '0, 1'b1);
        end
        checks++; if (o_valid !== 1'b0 || o_full !== m_full() || o_ready !== 1'b1) begin errors++; $display("FAIL full_empty got=%b%b%b exp=001", o_valid, o_full, o_ready); end
    endtask

    task automatic test_wrap();
        cycle('1, rand_row(), 1'b0);
        for (int n = 0; n < 200; n++) begin
            cycle('1, rand_row(), 1'b1);
            checks++; if (o_valid !== 1'b1 || out !== m_out()) begin errors++; $display("FAIL wrap n=%0d got=%b/%h exp=1/%h", n, o_valid, out, m_out()); end
        end
        cycle('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_spurious();
        logic [BW*COL-1:0] d = rand_row();
        cycle(~8'h20, d, 1'b0);
        repeat (3) begin
            cycle('0, '0, 1'b1);
            checks++; if (o_valid !== 1'b0 || out !== '0) begin errors++; $display("FAIL spur_rd got=%b/%h exp=0/0", o_valid, out); end
        end
        cycle(8'h20, rand_row(), 1'b0);
        checks++; if (o_valid !== 1'b1 || out !== m_out()) begin errors++; $display("FAIL spur_fill got=%b/%h exp=1/%h", o_valid, out, m_out()); end
        checks++; if (out[BW-1:0] !== d[BW-1:0]) begin errors++; $display("FAIL spur_head got=%h exp=%h", out[BW-1:0], d[BW-1:0]); end
        cycle('0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [BW*COL-1:0] d;
        repeat (10) cycle('1, rand_row(), 1'b0);
        #3 reset = 1'b1;
        #1;
        checks++; if (out !== '0 || o_valid !== 1'b0) begin errors++; $display("FAIL rmid_out got=%b/%h exp=0/0", o_valid, out); end
        checks++; if (o_ovf !== '0 || o_ready !== 1'b1) begin errors++; $display("FAIL rmid_flags got=%h/%b exp=00/1", o_ovf, o_ready); end
        m_clear();
        @(negedge clk); reset = 1'b0;
        d = rand_row();
        cycle('1, d, 1'b0);
        checks++; if (o_valid !== 1'b1 || out !== d) begin errors++; $display("FAIL rmid_row got=%b/%h exp=1/%h", o_valid, out, d); end
        cycle('0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0 || out !== m_out()) begin errors++; $display("FAIL rmid_pop got=%b/%h exp=0/0", o_valid, out); end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_back_to_back();
        test_full_ovf();
        test_wrap();
        test_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
